// File: rtl/slip_uart_tx_framer.sv
// rtl/slip_uart_tx_framer.sv - byte FIFO, SLIP encoder and single-byte UART issuer
module slip_uart_tx_framer #(
    parameter int          DEPTH_LOG2   = 4,
    parameter logic [7:0]  SLIP_END     = 8'hC0,
    parameter logic [7:0]  SLIP_ESC     = 8'hDB,
    parameter logic [7:0]  SLIP_ESC_END = 8'hDC,
    parameter logic [7:0]  SLIP_ESC_ESC = 8'hDD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fifo_level,
    input  logic                  tx_free,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    output logic                  busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_SUB, S_STOP} state_t;

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_en;
    logic                  pop;
    logic                  fifo_empty;
    logic [7:0]            head_data;
    logic                  head_last;

    logic                  pending;
    logic                  wait_ack;
    logic [7:0]            hold;
    logic                  issuer_ready;
    logic                  load;
    logic [7:0]            load_byte;

    state_t                state;
    state_t                state_next;
    logic [7:0]            sub;
    logic [7:0]            sub_next;
    logic                  sub_last;
    logic                  sub_last_next;

    assign in_ready     = (fifo_level != FULL_LEVEL);
    assign wr_en        = in_valid && in_ready;
    assign overflow     = in_valid && !in_ready;
    assign fifo_empty   = (fifo_level == '0);
    assign head_data    = mem[rd_ptr][7:0];
    assign head_last    = mem[rd_ptr][8];
    assign issuer_ready = !pending && !wait_ack;
    assign busy         = (state != S_IDLE) || pending || wait_ack || !fifo_empty;

    // FIFO storage: data array needs no reset, only pointers and level do
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    // FIFO pointers and occupancy; level is registered so a write shows up next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + (DEPTH_LOG2+1)'(wr_en) - (DEPTH_LOG2+1)'(pop);
        end
    end

    // Issuer: holds one byte, pulses transmit when the UART is free, then waits for tx_free to drop
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            wait_ack <= 1'b0;
            hold     <= '0;
            tx_byte  <= '0;
            transmit <= 1'b0;
        end else begin
            transmit <= 1'b0;
            if (pending && tx_free && !wait_ack) begin
                transmit <= 1'b1;
                tx_byte  <= hold;
                wait_ack <= 1'b1;
                pending  <= 1'b0;
            end else if (wait_ack && !tx_free) begin
                wait_ack <= 1'b0;
            end
            if (load) begin
                pending <= 1'b1;
                hold    <= load_byte;
            end
        end
    end

    // Encoder state register and saved substitute byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sub      <= '0;
            sub_last <= 1'b0;
        end else begin
            state    <= state_next;
            sub      <= sub_next;
            sub_last <= sub_last_next;
        end
    end

    // Encoder next-state: each emit hands one byte to the issuer; FIFO pops only on that handoff
    always_comb begin
        state_next    = state;
        sub_next      = sub;
        sub_last_next = sub_last;
        load          = 1'b0;
        load_byte     = '0;
        pop           = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && issuer_ready) begin
                    load       = 1'b1;
                    load_byte  = SLIP_END;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (!fifo_empty && issuer_ready) begin
                    load = 1'b1;
                    pop  = 1'b1;
                    if (head_data == SLIP_END || head_data == SLIP_ESC) begin
                        load_byte     = SLIP_ESC;
                        sub_next      = (head_data == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
                        sub_last_next = head_last;
                        state_next    = S_SUB;
                    end else begin
                        load_byte  = head_data;
                        state_next = head_last ? S_STOP : S_DATA;
                    end
                end
            end
            S_SUB: begin
                if (issuer_ready) begin
                    load       = 1'b1;
                    load_byte  = sub;
                    state_next = sub_last ? S_STOP : S_DATA;
                end
            end
            S_STOP: begin
                if (issuer_ready) begin
                    load       = 1'b1;
                    load_byte  = SLIP_END;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_slip_uart_tx_framer.sv
// tb/tb_slip_uart_tx_framer.sv - self-checking bench for slip_uart_tx_framer
module tb_slip_uart_tx_framer;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic          overflow;
    logic [DL:0]   fifo_level;
    logic          tx_free;
    logic          transmit;
    logic [7:0]    tx_byte;
    logic          busy;

    slip_uart_tx_framer #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .overflow(overflow), .fifo_level(fifo_level), .tx_free(tx_free),
        .transmit(transmit), .tx_byte(tx_byte), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        int          n;
        logic [31:0] e;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         uart_mode = 0;
    int         busy_len = 4;
    logic       prev_tx = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture every transmitted byte; a pulse must never follow another pulse directly
    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            got.push_back(tx_byte);
            check("single_cycle_pulse", {31'd0, prev_tx}, 32'd0);
        end
        prev_tx = transmit;
    end

    // UART model: mode 0 drops tx_free for busy_len cycles per byte, mode 1 holds it low, mode 2 is manual
    initial begin
        forever begin
            @(negedge clk);
            if (uart_mode == 0 && transmit === 1'b1) begin
                tx_free = 1'b0;
                repeat (busy_len) @(negedge clk);
                if (uart_mode == 0) tx_free = 1'b1;
            end else if (uart_mode == 1) begin
                tx_free = 1'b0;
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input logic l, output logic ovf, output logic rdy);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        #1;
        ovf = overflow;
        rdy = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, {31'd0, n >= 4000}, 32'd0);
        repeat (busy_len + 3) @(negedge clk);
    endtask

    task automatic model_packet(input logic [7:0] pkt[$]);
        exp_q.push_back(8'hC0);
        foreach (pkt[i]) begin
            if (pkt[i] == 8'hC0) begin
                exp_q.push_back(8'hDB); exp_q.push_back(8'hDC);
            end else if (pkt[i] == 8'hDB) begin
                exp_q.push_back(8'hDB); exp_q.push_back(8'hDD);
            end else begin
                exp_q.push_back(pkt[i]);
            end
        end
        exp_q.push_back(8'hC0);
    endtask

    task automatic compare_q(input string name);
        int m;
        check({name, "_count"}, got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({name, "_byte"}, {24'd0, got[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic wait_got(input string name, input int cnt);
        int n = 0;
        while (got.size() < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_wait_timeout"}, {31'd0, n >= 2000}, 32'd0);
    endtask

    initial begin
        vec_t       tbl[6];
        logic       ovf;
        logic       rdy;
        logic [7:0] pkt[$];
        int         bad;

        tbl[0] = '{d: 8'h11, n: 3, e: 32'hC011C000};
        tbl[1] = '{d: 8'hC0, n: 4, e: 32'hC0DBDCC0};
        tbl[2] = '{d: 8'hDB, n: 4, e: 32'hC0DBDDC0};
        tbl[3] = '{d: 8'hDC, n: 3, e: 32'hC0DCC000};
        tbl[4] = '{d: 8'h00, n: 3, e: 32'hC000C000};
        tbl[5] = '{d: 8'hFF, n: 3, e: 32'hC0FFC000};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; tx_free = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_transmit", {31'd0, transmit}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_fifo_level", {27'd0, fifo_level}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] e;
            e = tbl[i].e;
            got.delete();
            write_byte(tbl[i].d, 1'b1, ovf, rdy);
            drain("table");
            check("table_count", got.size(), tbl[i].n);
            for (int j = 0; j < tbl[i].n && j < got.size(); j++)
                check("table_byte", {24'd0, got[j]}, {24'd0, e[31-8*j -: 8]});
        end

        busy_len = 40;
        got.delete(); exp_q = '{8'hC0, 8'h11, 8'h22, 8'hC0};
        write_byte(8'h11, 1'b0, ovf, rdy);
        write_byte(8'h22, 1'b1, ovf, rdy);
        drain("single");
        compare_q("single");

        busy_len = 4;
        got.delete(); exp_q.delete(); pkt = '{8'hC0, 8'hDB, 8'h05}; model_packet(pkt);
        foreach (pkt[i]) write_byte(pkt[i], i == 2, ovf, rdy);
        drain("escape");
        compare_q("escape");

        uart_mode = 1; tx_free = 1'b0;
        got.delete(); exp_q.delete(); pkt.delete();
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            write_byte(8'(k), k == 16, ovf, rdy);
            if (k == 16) check("ovf_16th_no_pulse", {31'd0, ovf}, 32'd0);
            pkt.push_back(8'(k));
        end
        #1;
        check("ovf_in_ready_full", {31'd0, in_ready}, 32'd0);
        check("ovf_level_full", {27'd0, fifo_level}, 32'd16);
        @(negedge clk);
        write_byte(8'hEE, 1'b1, ovf, rdy);
        check("ovf_17th_pulse", {31'd0, ovf}, 32'd1);
        #1;
        check("ovf_pulse_one_cycle", {31'd0, overflow}, 32'd0);
        check("ovf_level_kept", {27'd0, fifo_level}, 32'd16);
        check("ovf_nothing_sent", got.size(), 0);
        uart_mode = 0; tx_free = 1'b1;
        model_packet(pkt);
        drain("overflow");
        compare_q("overflow");

        got.delete(); exp_q = '{8'hC0, 8'h01, 8'h02, 8'hC0};
        write_byte(8'h01, 1'b0, ovf, rdy);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        check("starve_busy_low_cycles", bad, 0);
        check("starve_no_extra_end", got.size(), 2);
        write_byte(8'h02, 1'b1, ovf, rdy);
        drain("starve");
        compare_q("starve");

        uart_mode = 2; tx_free = 1'b1;
        got.delete(); exp_q = '{8'hC0, 8'h33, 8'hC0};
        write_byte(8'h33, 1'b1, ovf, rdy);
        wait_got("hs_first", 1);
        repeat (3) @(negedge clk);
        check("hs_no_second_while_free_high", got.size(), 1);
        tx_free = 1'b0;
        @(negedge clk);
        tx_free = 1'b1;
        wait_got("hs_second", 2);
        tx_free = 1'b0;
        @(negedge clk);
        tx_free = 1'b1;
        uart_mode = 0;
        drain("handshake");
        compare_q("handshake");

        busy_len = 40;
        got.delete();
        write_byte(8'h44, 1'b0, ovf, rdy);
        write_byte(8'h55, 1'b1, ovf, rdy);
        wait_got("rst_mid", 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_transmit", {31'd0, transmit}, 32'd0);
        check("rst_mid_level", {27'd0, fifo_level}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        got.delete(); exp_q = '{8'hC0, 8'h66, 8'hC0};
        write_byte(8'h66, 1'b1, ovf, rdy);
        drain("after_rst");
        compare_q("after_rst");

        busy_len = 2;
        got.delete(); exp_q.delete();
        for (int p = 0; p < 6; p++) begin
            int len;
            len = $urandom_range(1, 6);
            pkt.delete();
            for (int b = 0; b < len; b++) begin
                int r;
                int n;
                logic [7:0] d;
                r = $urandom_range(0, 3);
                d = (r == 0) ? 8'hC0 : (r == 1) ? 8'hDB : 8'($urandom);
                pkt.push_back(d);
                n = 0;
                while (in_ready !== 1'b1 && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                write_byte(d, b == len - 1, ovf, rdy);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            model_packet(pkt);
        end
        drain("random");
        compare_q("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
